// File: rtl/demux.sv
// ============================================================================
//  Module      : demux
//  Description : One-to-three demultiplexer with a one-word registered buffer
//                per destination and valid/ready handshakes on every port.
//                Optional drop counter enabled by DEMUX_DROP_COUNT_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module demux #(
    parameter int WIDTH = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] ip,
    input  logic             ip_valid,
    output logic             ip_ready,
    input  logic             sel1,
    input  logic             sel2,
    input  logic             sel3,
    output logic [WIDTH-1:0] op1,
    output logic [WIDTH-1:0] op2,
    output logic [WIDTH-1:0] op3,
    output logic             op1_valid,
    output logic             op2_valid,
    output logic             op3_valid,
    input  logic             op1_ready,
    input  logic             op2_ready,
    input  logic             op3_ready
`ifdef DEMUX_DROP_COUNT_EN
    ,
    output logic [7:0]       drop_count
`endif
);

    localparam logic [1:0] c_DEST_NONE = 2'd0;
    localparam logic [1:0] c_DEST_1    = 2'd1;
    localparam logic [1:0] c_DEST_2    = 2'd2;
    localparam logic [1:0] c_DEST_3    = 2'd3;

    logic [WIDTH-1:0] r_data [3];
    logic [2:0]       r_valid;
    logic [2:0]       w_op_ready;
    logic [1:0]       w_dest;
    logic             w_xfer;
    logic [2:0]       w_load;

    assign w_op_ready = {op3_ready, op2_ready, op1_ready};

    // Fixed priority: sel1 over sel2 over sel3.
    always_comb begin
        w_dest = c_DEST_NONE;
        if (sel1)
            w_dest = c_DEST_1;
        else if (sel2)
            w_dest = c_DEST_2;
        else if (sel3)
            w_dest = c_DEST_3;
    end

    always_comb begin
        ip_ready = 1'b1;
        case (w_dest)
            c_DEST_1: ip_ready = !r_valid[0] || w_op_ready[0];
            c_DEST_2: ip_ready = !r_valid[1] || w_op_ready[1];
            c_DEST_3: ip_ready = !r_valid[2] || w_op_ready[2];
            default:  ip_ready = 1'b1;
        endcase
    end

    assign w_xfer = ip_valid && ip_ready;

    generate
        for (genvar g = 0; g < 3; g++) begin : g_chan
            assign w_load[g] = w_xfer && (w_dest == 2'(g + 1));

            // A load wins over a drain so a same-cycle drain+load keeps the new word.
            always_ff @(posedge clock) begin
                if (reset) begin
                    r_data[g]  <= '0;
                    r_valid[g] <= 1'b0;
                end else if (w_load[g]) begin
                    r_data[g]  <= ip;
                    r_valid[g] <= 1'b1;
                end else if (r_valid[g] && w_op_ready[g]) begin
                    r_valid[g] <= 1'b0;
                end
            end
        end
    endgenerate

    assign op1       = r_data[0];
    assign op2       = r_data[1];
    assign op3       = r_data[2];
    assign op1_valid = r_valid[0];
    assign op2_valid = r_valid[1];
    assign op3_valid = r_valid[2];

`ifdef DEMUX_DROP_COUNT_EN
    logic [7:0] r_drop_count;

    always_ff @(posedge clock) begin
        if (reset)
            r_drop_count <= 8'd0;
        else if (w_xfer && (w_dest == c_DEST_NONE) && (r_drop_count != 8'hFF))
            r_drop_count <= r_drop_count + 8'd1;
    end

    assign drop_count = r_drop_count;
`endif

endmodule

`default_nettype wire

// File: tb/tb_demux.sv
// ============================================================================
//  Module      : tb_demux
//  Description : Directed self-checking bench for demux.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_demux;

    localparam int WIDTH = 4;

    logic             clock;
    logic             reset;
    logic [WIDTH-1:0] ip;
    logic             ip_valid;
    logic             ip_ready;
    logic             sel1, sel2, sel3;
    logic [WIDTH-1:0] op1, op2, op3;
    logic             op1_valid, op2_valid, op3_valid;
    logic             op1_ready, op2_ready, op3_ready;
`ifdef DEMUX_DROP_COUNT_EN
    logic [7:0]       drop_count;
`endif

    int n_tests = 0;
    int n_fail  = 0;
    int r_op3_taken = 0;

    demux #(.WIDTH(WIDTH)) u_dut (
        .clock     (clock),
        .reset     (reset),
        .ip        (ip),
        .ip_valid  (ip_valid),
        .ip_ready  (ip_ready),
        .sel1      (sel1),
        .sel2      (sel2),
        .sel3      (sel3),
        .op1       (op1),
        .op2       (op2),
        .op3       (op3),
        .op1_valid (op1_valid),
        .op2_valid (op2_valid),
        .op3_valid (op3_valid),
        .op1_ready (op1_ready),
        .op2_ready (op2_ready),
        .op3_ready (op3_ready)
`ifdef DEMUX_DROP_COUNT_EN
        ,
        .drop_count(drop_count)
`endif
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(posedge clock)
        if (!reset && op3_valid && op3_ready)
            r_op3_taken <= r_op3_taken + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic drive(input logic v, input logic [3:0] d, input logic s1, input logic s2, input logic s3);
        ip_valid = v;
        ip       = d;
        sel1     = s1;
        sel2     = s2;
        sel3     = s3;
        #1;
    endtask

    initial begin
        int base;
        int bad_ready;
        reset = 1'b1;
        op1_ready = 1'b0; op2_ready = 1'b0; op3_ready = 1'b0;
        drive(1'b0, 4'h0, 1'b0, 1'b0, 1'b0);
        step(); step();
        reset = 1'b0;

        check("rst_op1_valid", op1_valid, 0);
        check("rst_op2_valid", op2_valid, 0);
        check("rst_op3_valid", op3_valid, 0);
        check("rst_data", {op1, op2, op3}, 0);
        check("rst_ip_ready", ip_ready, 1);

        // sel1 outranks sel2
        drive(1'b1, 4'hA, 1'b1, 1'b1, 1'b0);
        check("prio_ready", ip_ready, 1);
        step();
        drive(1'b0, 4'h0, 1'b0, 1'b0, 1'b0);
        check("prio_op1", op1, 4'hA);
        check("prio_op1_valid", op1_valid, 1);
        check("prio_op2_valid", op2_valid, 0);

        // op1 stalled must not block op2
        drive(1'b1, 4'hC, 1'b0, 1'b1, 1'b0);
        check("nonblock_ready", ip_ready, 1);
        step();
        drive(1'b0, 4'h0, 1'b0, 1'b0, 1'b0);
        check("nonblock_op2", op2, 4'hC);
        check("nonblock_op2_valid", op2_valid, 1);
        check("nonblock_op1_hold", op1, 4'hA);

        // traffic to a full op1 stalls; re-select to op3 proceeds
        drive(1'b1, 4'hB, 1'b1, 1'b0, 1'b0);
        check("stall1_ready", ip_ready, 0);
        step();
        check("stall1_op1", op1, 4'hA);
        check("stall1_valid", op1_valid, 1);
        drive(1'b1, 4'hB, 1'b0, 1'b0, 1'b1);
        check("resel_ready", ip_ready, 1);
        step();
        drive(1'b0, 4'h0, 1'b0, 1'b0, 1'b0);
        check("resel_op3", op3, 4'hB);
        check("resel_op1", op1, 4'hA);

        // simultaneous drain and load of op2
        op2_ready = 1'b1;
        drive(1'b1, 4'h3, 1'b0, 1'b1, 1'b0);
        check("dl_ready", ip_ready, 1);
        step();
        op2_ready = 1'b0;
        drive(1'b1, 4'h5, 1'b0, 1'b1, 1'b0);
        check("dl_op2", op2, 4'h3);
        check("dl_op2_valid", op2_valid, 1);
        check("full2_ready", ip_ready, 0);
        step();
        check("full2_hold", op2, 4'h3);
        op2_ready = 1'b1;
        #1;
        check("full2_ready_up", ip_ready, 1);
        step();
        op2_ready = 1'b0;
        drive(1'b0, 4'h0, 1'b0, 1'b0, 1'b0);
        check("full2_op2", op2, 4'h5);
        check("full2_op2_valid", op2_valid, 1);

        // op3 holds B; load 7 while draining, then 9 while draining
        op3_ready = 1'b1;
        base = r_op3_taken;
        drive(1'b1, 4'h7, 1'b0, 1'b0, 1'b1);
        step();
        check("op3_seven", op3, 4'h7);
        base = r_op3_taken;
        drive(1'b1, 4'h9, 1'b0, 1'b0, 1'b1);
        check("op3_ready9", ip_ready, 1);
        step();
        drive(1'b0, 4'h0, 1'b0, 1'b0, 1'b0);
        check("op3_nine", op3, 4'h9);
        check("op3_nine_valid", op3_valid, 1);
        step();
        check("op3_words", r_op3_taken - base, 2);
        check("op3_empty", op3_valid, 0);

        // ready on an empty output has no effect
        step();
        check("ready_empty", op3_valid, 0);
        op3_ready = 1'b0;

        // no-select traffic is accepted and discarded
        bad_ready = 0;
        drive(1'b1, 4'hF, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 260; i++) begin
            if (ip_ready !== 1'b1) bad_ready++;
`ifdef DEMUX_DROP_COUNT_EN
            if (i == 3) check("drop_3", drop_count, 3);
`endif
            step();
        end
        check("drop_ready", bad_ready, 0);
        check("drop_valids", {op1_valid, op2_valid, op3_valid}, 3'b110);
        check("drop_data", {op1, op2}, 8'hA5);
`ifdef DEMUX_DROP_COUNT_EN
        check("drop_sat", drop_count, 255);
`endif

        // fill op3 then reset with all outputs full
        drive(1'b1, 4'hE, 1'b0, 1'b0, 1'b1);
        step();
        check("fill_all", {op1_valid, op2_valid, op3_valid}, 3'b111);
        drive(1'b1, 4'h6, 1'b0, 1'b0, 1'b0);
        reset = 1'b1;
        step();
        reset = 1'b0;
        drive(1'b0, 4'h0, 1'b0, 1'b0, 1'b0);
        check("mid_rst_valid", {op1_valid, op2_valid, op3_valid}, 0);
        check("mid_rst_data", {op1, op2, op3}, 0);
`ifdef DEMUX_DROP_COUNT_EN
        check("mid_rst_drop", drop_count, 0);
`endif

        op1_ready = 1'b1;
        step();
        check("post_rst_empty", op1_valid, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/demux.md
DEMUX -- requirements
Module: demux

Interface
REQ-001 WIDTH, default 4, data width of ip and each output.
REQ-002 clock  input  1  rising-edge clock for all state.
REQ-003 reset  input  1  synchronous, active-high reset, sampled on posedge clock.
REQ-004 ip  input  WIDTH  input data word.
REQ-005 ip_valid  input  1  ip holds a word offered for transfer.
REQ-006 ip_ready  output  1  block accepts ip this cycle (combinational).
REQ-007 sel1, sel2, sel3  input  1 each  destination selects; priority sel1 > sel2 > sel3.
REQ-008 op1, op2, op3  output  WIDTH each  registered output data per destination.
REQ-009 op1_valid, op2_valid, op3_valid  output  1 each  output N holds a word not yet taken.
REQ-010 op1_ready, op2_ready, op3_ready  input  1 each  downstream N takes opN this cycle.
REQ-011 drop_count  output  8  words discarded with no select (present only with DEMUX_DROP_COUNT_EN).

Function
REQ-012 The destination SHALL be 1 if sel1, else 2 if sel2, else 3 if sel3, else none; sel is evaluated in the same cycle as ip_valid.
REQ-013 ip_ready SHALL be 1 when the destination is none, else (!opN_valid || opN_ready) for destination N.
REQ-014 A transfer SHALL occur on a posedge where ip_valid && ip_ready.
REQ-015 On a transfer to N, opN SHALL load ip and opN_valid SHALL be 1 from the next cycle (latency 1).
REQ-016 A transfer with destination none SHALL be accepted and discarded; no output changes.
REQ-017 opN_valid SHALL clear when opN_valid && opN_ready and no transfer loads N that cycle.
REQ-018 Simultaneous drain and load of N SHALL leave opN_valid 1 with the new word; no word lost or duplicated.
REQ-019 While opN_valid && !opN_ready, opN SHALL hold stable.
REQ-020 Outputs not selected SHALL retain their data and valid unchanged.
REQ-021 Each output SHALL buffer at most one word; a full, non-draining output SHALL stall only traffic addressed to it.
REQ-022 A change of sel while ip_valid is stalled SHALL re-evaluate destination and ip_ready in that cycle.
REQ-023 opN_ready while !opN_valid SHALL have no effect.

Reset
REQ-024 On reset, op1..op3 SHALL be 0, op1_valid..op3_valid 0, drop_count 0.
REQ-025 Reset mid-operation SHALL discard buffered words; no transfer or drop is counted in a reset cycle.
REQ-026 ip_ready SHALL follow REQ-013 during reset (all outputs empty after the reset edge).

Configuration
REQ-027 Macro DEMUX_DROP_COUNT_EN defined: drop_count port present; increments by 1 per REQ-016 discard; saturates at 255.
REQ-028 Macro DEMUX_DROP_COUNT_EN undefined: drop_count port and counter logic absent; all other behaviour identical.

Verification
REQ-029 reset, then ip=4'hA, ip_valid=1, sel1=1, sel2=1 for 1 cycle, op1_ready=0 -> next cycle op1=4'hA, op1_valid=1, op2_valid=0.
REQ-030 op2 full (4'h3), op2_ready=0, ip=4'h5 sel2=1 sel1=0 ip_valid=1 -> ip_ready=0, op2 stays 4'h3; raise op2_ready -> same edge accepts, next cycle op2=4'h5, op2_valid=1.
REQ-031 op3 holds 4'h7 with op3_ready=1 while ip=4'h9 sel3=1 -> ip_ready=1, next cycle op3=4'h9, op3_valid=1, exactly two words seen at op3.
REQ-032 op1 full and stalled, ip=4'hC sel2=1 sel1=0 -> ip_ready=1, op2=4'hC next cycle, op1 unchanged.
REQ-033 DEMUX_DROP_COUNT_EN defined, 260 cycles ip_valid=1 with no sel -> ip_ready=1 throughout, no opN_valid, drop_count=255.
REQ-034 reset asserted 1 cycle with all three outputs full -> all opN_valid=0, opN=0, drop_count=0 next cycle.
